bsg_counter_set_down_multi: RTL
===============================

BSG_COUNTER_SET_DOWN_MULTI -- requirements
Module: bsg_counter_set_down_multi

Interface
REQ-001 Parameter: width_p, 16, counter width in bits per channel (>=2).
REQ-002 Parameter: els_p, 4, number of independent counter channels (>=1).
REQ-003 Port: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: set_i  input  els_p  per-channel load strobe.
REQ-006 Port: val_i  input  els_p*width_p  per-channel load value; channel i at bits [i*width_p +: width_p].
REQ-007 Port: mode_i  input  els_p  per-channel mode, sampled only with set_i: 0 one-shot, 1 auto-reload.
REQ-008 Port: down_i  input  els_p  per-channel decrement enable.
REQ-009 Port: count_r_o  output  els_p*width_p  registered count per channel, same packing as val_i.
REQ-010 Port: zero_o  output  els_p  per-channel flag, high when that channel's count_r equals 0.
REQ-011 Port: expire_o  output  els_p  per-channel registered one-cycle pulse on terminal count.

Function
REQ-012 Each channel SHALL hold count_r, reload_r (width_p) and mode_r (1 bit); channels SHALL be fully independent.
REQ-013 Priority per channel per cycle SHALL be: reset > set > down > hold.
REQ-014 On set_i[i]: count_r<=val, reload_r<=val, mode_r<=mode_i[i]; expire_o[i] 0 next cycle; down_i[i] ignored that cycle.
REQ-015 On down_i[i] with count_r>1: count_r<=count_r-1, expire_o 0 next cycle.
REQ-016 On down_i[i] with count_r==1, mode_r==0: count_r<=0, expire_o[i]=1 next cycle.
REQ-017 On down_i[i] with count_r==1, mode_r==1: count_r<=reload_r, expire_o[i]=1 next cycle.
REQ-018 On down_i[i] with count_r==0: count_r SHALL stay 0 (saturate, never wrap to all-ones), expire_o 0.
REQ-019 Auto-reload with reload_r==1: every down cycle SHALL produce expire pulse and count stays 1.
REQ-020 Set with val==0 SHALL give count_r=0, zero_o=1, no expire pulse.
REQ-021 Idle cycle (no set, no down): count_r, reload_r, mode_r hold; expire_o 0.
REQ-022 count_r_o SHALL reflect a set/down on the cycle after the triggering edge (latency 1); zero_o SHALL be combinational from count_r.
REQ-023 expire_o SHALL be registered and high for exactly one cycle per terminal event; back-to-back events yield consecutive pulses.

Reset
REQ-024 Asserting reset_i SHALL immediately (without clock) force count_r=0, reload_r=0, mode_r=0, expire_o=0, hence zero_o=all ones.
REQ-025 Reset asserted mid-count SHALL discard all channel state; after deassertion channels idle at 0 until set.
REQ-026 set_i/down_i during reset SHALL have no effect.

Structure
REQ-027 A shared package bsg_counter_pkg SHALL hold the mode encoding constants (one-shot=0, auto-reload=1).
REQ-028 One sub-module bsg_counter_set_down_ch SHALL implement a single channel (count_r, reload_r, mode_r, expire); top instantiates els_p copies via generate.
REQ-029 No combinational path from set_i/val_i/down_i/mode_i to any output.

Verification
REQ-030 Reset then idle: count_r_o=0 all channels, zero_o=4'b1111, expire_o=0.
REQ-031 Ch0 set val=3 mode=0, down x4: counts 3,2,1,0,0; expire_o[0] high only in cycle count shows 0 first; no wrap to 16'hFFFF.
REQ-032 Ch1 set val=2 mode=1, down x5: counts 2,1,2,1,2,1; expire_o[1] pulses after each 1->reload transition.
REQ-033 Ch2 count=5, set val=9 and down same cycle: count=9 next cycle, no expire.
REQ-034 Ch3 set 16'hFFFF while ch0 decrements: channels independent; ch3 holds 16'hFFFF, ch0 decrements.
REQ-035 Reset asserted asynchronously mid-count (ch1 at 1, auto-reload): outputs zero before next edge; after release, down yields no reload, no expire.

Source files
------------

// File: rtl/bsg_counter_pkg.sv
// Shared mode encoding for the set/down counter channels.
// One-shot stops at zero; auto-reload restarts from the loaded value.
package bsg_counter_pkg;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } mode_e;

  localparam logic MODE_ONESHOT_C = 1'b0;
  localparam logic MODE_RELOAD_C  = 1'b1;

endpackage

// File: rtl/bsg_counter_set_down_ch.sv
// One counter channel: load, decrement, saturate or reload at terminal.
// expire_o is a registered one-cycle pulse on the 1->0/reload step.
module bsg_counter_set_down_ch
  import bsg_counter_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               mode_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o,
  output logic               zero_o,
  output logic               expire_o
);

  localparam logic [width_p-1:0] one_lp = width_p'(1);

  logic [width_p-1:0] count_r;
  logic [width_p-1:0] reload_r;
  mode_e              mode_r;
  logic               expire_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r  <= '0;
      reload_r <= '0;
      mode_r   <= MODE_ONESHOT;
      expire_r <= 1'b0;
    end else begin
      expire_r <= 1'b0;
      if (set_i) begin
        count_r  <= val_i;
        reload_r <= val_i;
        mode_r   <= mode_e'(mode_i);
      end else if (down_i) begin
        if (count_r > one_lp) begin
          count_r <= count_r - one_lp;
        end else if (count_r == one_lp) begin
          expire_r <= 1'b1;
          count_r  <= (mode_r == MODE_RELOAD) ? reload_r : '0;
        end
        // a zero count saturates rather than wrapping
      end
    end
  end

  assign count_r_o = count_r;
  assign zero_o    = (count_r == '0);
  assign expire_o  = expire_r;

endmodule

// File: rtl/bsg_counter_set_down_multi.sv
// Bank of els_p independent set/down counters.
// Channel i occupies bits [i*width_p +: width_p] of val_i/count_r_o.
module bsg_counter_set_down_multi
  import bsg_counter_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         set_i,
  input  logic [els_p*width_p-1:0] val_i,
  input  logic [els_p-1:0]         mode_i,
  input  logic [els_p-1:0]         down_i,
  output logic [els_p*width_p-1:0] count_r_o,
  output logic [els_p-1:0]         zero_o,
  output logic [els_p-1:0]         expire_o
);

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    bsg_counter_set_down_ch #(
      .width_p(width_p)
    ) u_ch (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .set_i    (set_i[i]),
      .val_i    (val_i[i*width_p +: width_p]),
      .mode_i   (mode_i[i]),
      .down_i   (down_i[i]),
      .count_r_o(count_r_o[i*width_p +: width_p]),
      .zero_o   (zero_o[i]),
      .expire_o (expire_o[i])
    );
  end

endmodule
